calculate_cube: RTL and testbench
=================================

// Module: calculate_cube
// PURPOSE
//  Inverse companion of the cube-root unit: computes res = num^3 (unsigned) with a
//  sequential shift-add multiplier run in two passes (num*num, then square*num).
//  Uses the same level handshake as the root unit (ready_to_calc in, ready out).
//  Lets the system cube values and cross-check root results on chip; overflow flags
//  cubes that do not fit in WIDTH bits.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=2); sets pass length and latency
// PORTS
//  clk            in   1      rising-edge clock, single clock domain
//  rst            in   1      synchronous active-high reset
//  ready_to_calc  in   1      level request; high = compute, low = abort/idle
//  num            in   WIDTH  unsigned operand, sampled once at start
//  ready          out  1      result valid; held while ready_to_calc stays high
//  res            out  WIDTH  low WIDTH bits of num^3 (registered)
//  overflow       out  1      1 = num^3 >= 2^WIDTH (registered, valid with res)
// BEHAVIOUR
//  - Reset: one clk edge with rst=1 -> state IDLE; ready=0, res=0, overflow=0,
//    internal accumulators and counter cleared. rst overrides every other input.
//  - States: IDLE, SQR, CUB, DONE. Counter cnt is 0..WIDTH-1.
//  - IDLE: edge with ready_to_calc=1 -> latch x=num, acc=0, cnt=0, go to SQR.
//    Otherwise stay in IDLE.
//  - SQR (WIDTH edges): if x[cnt] then acc += x<<cnt (acc is 2*WIDTH wide); cnt++.
//    On the edge with cnt=WIDTH-1: sq=final acc, acc3=0, cnt=0, go to CUB.
//  - CUB (WIDTH edges): if x[cnt] then acc3 += sq<<cnt (acc3 is 3*WIDTH wide);
//    cnt++. On the edge with cnt=WIDTH-1, in the same edge: res=acc3[WIDTH-1:0],
//    overflow=|acc3[3W-1:WIDTH], ready=1, go to DONE.
//  - DONE: hold ready=1, res and overflow while ready_to_calc=1. On an edge with
//    ready_to_calc=0 -> ready=0, go to IDLE.
//  - Latency: ready is 1 after edge 2*WIDTH+1, counting the start edge in IDLE as
//    edge 1 (65 edges for WIDTH=32). It is fixed and does not depend on data.
//  - Abort: ready_to_calc=0 on any edge in SQR or CUB -> go to IDLE.
//    ready stays 0. res and overflow keep their previous values.
//  - res/overflow change only on DONE entry or reset. They hold the last result
//    after ready drops.
//  - num changes after the start edge are ignored until the next start.
//  - A new computation needs ready_to_calc low for at least one edge, because
//    DONE always returns through IDLE.
//  - Arithmetic is unsigned and exact to 3*WIDTH bits. res wraps modulo 2^WIDTH.
//    For WIDTH=32, overflow=1 exactly when num>=1626.
// TESTING
//  1. num=3, hold ready_to_calc=1 -> ready rises after edge 65, res=27, overflow=0.
//  2. num=1625 -> res=4291015625, overflow=0.
//     num=1626 -> res=3975080, overflow=1.
//  3. num=0 then num=1, each after a low cycle -> res=0 then res=1.
//     ready stays low for the first 64 edges of each run.
//  4. Start with num=7, drop ready_to_calc at edge 20 -> ready never rises and
//     res keeps its prior value. Restart with num=5 -> res=125 after 65 edges.
//  5. Assert rst during CUB -> next cycle ready=0, res=0, overflow=0, state IDLE.
//     A following request num=10 -> res=1000.
//  6. Change num mid-run (start at 4, switch to 9 at edge 10) -> res=64.
//     Loopback: random N -> cube-root unit -> calculate_cube, check res<=N and
//     (root+1)^3>N.

Source files
------------

// File: rtl/calculate_cube.sv
// Sequential cube unit: res = num^3 via two shift-add passes (num*num, then square*num).
// Level handshake: ready_to_calc requests a result, ready flags it and holds it.
module calculate_cube #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready_to_calc,
  input  logic [WIDTH-1:0] num,
  output logic             ready,
  output logic [WIDTH-1:0] res,
  output logic             overflow
);

  localparam int unsigned CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned AW  = 2 * WIDTH;
  localparam int unsigned A3W = 3 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    CUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] x;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    sq;
  logic [A3W-1:0]   acc3;

  logic [AW-1:0]    acc_next_c;
  logic [A3W-1:0]   acc3_next_c;

  // Partial-product accumulation for the current bit of x in each pass.
  always_comb begin
    acc_next_c  = acc;
    acc3_next_c = acc3;
    if (x[cnt]) begin
      acc_next_c  = acc + (AW'(x) << cnt);
      acc3_next_c = acc3 + (A3W'(sq) << cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x        <= '0;
      cnt      <= '0;
      acc      <= '0;
      sq       <= '0;
      acc3     <= '0;
      ready    <= 1'b0;
      res      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (ready_to_calc) begin
            x     <= num;
            acc   <= '0;
            cnt   <= '0;
            state <= SQR;
          end
        end
        SQR: begin
          if (!ready_to_calc) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
            sq    <= acc_next_c;
            acc3  <= '0;
            cnt   <= '0;
            state <= CUB;
          end else begin
            acc <= acc_next_c;
            cnt <= cnt + CW'(1);
          end
        end
        CUB: begin
          if (!ready_to_calc) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
            acc3     <= acc3_next_c;
            res      <= acc3_next_c[WIDTH-1:0];
            overflow <= |acc3_next_c[A3W-1:WIDTH];
            ready    <= 1'b1;
            state    <= DONE;
          end else begin
            acc3 <= acc3_next_c;
            cnt  <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (!ready_to_calc) begin
            ready <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calculate_cube.sv
// Scoreboard bench for calculate_cube: stimulus pushes expected results, a monitor
// pops and checks them on every rising edge of ready.
module tb_calculate_cube;

  localparam int unsigned WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             ovf;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready_to_calc;
  logic [WIDTH-1:0] num;
  logic             ready;
  logic [WIDTH-1:0] res;
  logic             overflow;

  int   tests  = 0;
  int   fails  = 0;
  int   cyc    = 0;
  logic ready_q = 1'b0;
  exp_t sb[$];

  calculate_cube #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .ready_to_calc(ready_to_calc),
    .num          (num),
    .ready        (ready),
    .res          (res),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rising edge of ready must match the oldest expected result.
  always @(negedge clk) begin
    if (ready === 1'b1 && ready_q !== 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ready: got ready=1 with res=%0d, expected no result", res);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mon_res", 64'(res), 64'(e.res));
        check("mon_ovf", 64'(overflow), 64'(e.ovf));
        check("mon_latency", 64'(cyc), 64'(e.cyc));
      end
    end
    ready_q = ready;
  end

  // Full run: start, optionally switch num mid-run, hold result, then release.
  task automatic run_full(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] er,
                          input logic eo, input int sw_at, input logic [WIDTH-1:0] sw_num);
    exp_t e;
    @(negedge clk);
    num           = n;
    ready_to_calc = 1'b1;
    e.res = er; e.ovf = eo; e.cyc = cyc + 65;
    sb.push_back(e);
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (i == sw_at) num = sw_num;
    end
    check("not_ready_before_65", 64'(ready), 64'd0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("hold_ready", 64'(ready), 64'd1);
    check("hold_res", 64'(res), 64'(er));
    ready_to_calc = 1'b0;
    @(negedge clk);
    check("drop_ready", 64'(ready), 64'd0);
    check("keep_res", 64'(res), 64'(er));
  endtask

  initial begin
    logic [63:0] n64, r64;
    rst           = 1'b1;
    ready_to_calc = 1'b0;
    num           = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_res", 64'(res), 64'd0);
    check("reset_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;

    run_full(32'd3, 32'd27, 1'b0, 0, '0);
    run_full(32'd1625, 32'd4291015625, 1'b0, 0, '0);
    run_full(32'd1626, 32'd3975080, 1'b1, 0, '0);
    run_full(32'd0, 32'd0, 1'b0, 0, '0);
    run_full(32'd1, 32'd1, 1'b0, 0, '0);
    run_full(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, '0);

    // Abort at edge 20: no result, previous res held.
    @(negedge clk);
    num           = 32'd7;
    ready_to_calc = 1'b1;
    repeat (19) @(negedge clk);
    ready_to_calc = 1'b0;
    repeat (70) @(negedge clk);
    check("abort_ready", 64'(ready), 64'd0);
    check("abort_res", 64'(res), 64'hFFFF_FFFF);
    check("abort_ovf", 64'(overflow), 64'd1);
    run_full(32'd5, 32'd125, 1'b0, 0, '0);

    // Reset while in the cube pass.
    @(negedge clk);
    num           = 32'd2;
    ready_to_calc = 1'b1;
    repeat (40) @(negedge clk);
    rst           = 1'b1;
    ready_to_calc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_cub_ready", 64'(ready), 64'd0);
    check("rst_cub_res", 64'(res), 64'd0);
    check("rst_cub_ovf", 64'(overflow), 64'd0);
    run_full(32'd10, 32'd1000, 1'b0, 0, '0);

    // num changes after the start edge are ignored.
    run_full(32'd4, 32'd64, 1'b0, 9, 32'd9);

    // Loopback: floor cube root of a random N, cubed again, must not exceed N.
    for (int k = 0; k < 2; k++) begin
      n64 = 64'($urandom_range(32'hFFFF_FFFE, 1));
      r64 = 0;
      while ((r64 + 1) * (r64 + 1) * (r64 + 1) <= n64) r64++;
      run_full(WIDTH'(r64), WIDTH'(r64 * r64 * r64), 1'b0, 0, '0);
      tests++;
      if (64'(res) > n64) begin
        fails++;
        $display("FAIL loopback_le: got res=%0d, required <= %0d", res, n64);
      end
    end

    repeat (5) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL pending_results: got %0d outstanding, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
